// File: rtl/uart_tx_cfg.sv
// UART transmitter with a word-wide FIFO in front and a runtime baud divisor.
// Frame format and flow control are fixed per instance through parameters.
module uart_tx_cfg #(
    parameter int CLK_DIV_W  = 16,
    parameter int FIFO_ASIZE = 9,
    parameter int BYTE_WIDTH = 1,
    parameter int BIG_ENDIAN = 0,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int USE_CTS    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CLK_DIV_W-1:0]    cfg_div,
    input  logic                    wreq,
    output logic                    wgnt,
    input  logic [BYTE_WIDTH*8-1:0] wdata,
    output logic [FIFO_ASIZE-1:0]   fifo_level,
    input  logic                    i_cts_n,
    output logic                    idle,
    output logic                    o_uart_tx
);
    localparam int WORD_W = BYTE_WIDTH * 8;
    localparam int DEPTH  = 1 << FIFO_ASIZE;
    localparam int BI_W   = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;

    localparam logic [FIFO_ASIZE-1:0] PTR_ONE   = FIFO_ASIZE'(1);
    localparam logic [CLK_DIV_W-1:0]  DIV_ONE   = CLK_DIV_W'(1);
    localparam logic [CLK_DIV_W-1:0]  DIV_MIN   = CLK_DIV_W'(2);
    localparam logic [2:0]            LAST_DBIT = 3'(DATA_BITS - 1);
    localparam logic [2:0]            LAST_SBIT = 3'(STOP_BITS - 1);
    localparam logic [BI_W-1:0]       LAST_BYTE = BI_W'(BYTE_WIDTH - 1);
    localparam logic [BI_W-1:0]       BYTE_ONE  = BI_W'(1);
    localparam logic [7:0]            DATA_MASK = 8'((1 << DATA_BITS) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t state, state_nx;

    // ---------------- FIFO ----------------
    logic [WORD_W-1:0]     mem [DEPTH];
    logic [FIFO_ASIZE-1:0] wr_ptr, rd_ptr;
    logic [WORD_W-1:0]     rd_data;
    logic                  full, empty, push, pop;
    logic [1:0]            cts_sync;
    logic                  cts_ok;

    assign full       = (wr_ptr + PTR_ONE) == rd_ptr;
    assign empty      = wr_ptr == rd_ptr;
    assign wgnt       = wreq & ~full;
    assign push       = wgnt;
    assign fifo_level = wr_ptr - rd_ptr;
    assign cts_ok     = (USE_CTS == 0) | ~cts_sync[1];
    assign pop        = (state == S_IDLE) & ~empty & cts_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cts_sync <= 2'b11;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            cts_sync <= {cts_sync[0], i_cts_n};
        end
    end

    // Storage and registered read port kept reset-free so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
        if (pop)  rd_data <= mem[rd_ptr];
    end

    // ---------------- frame datapath ----------------
    logic [WORD_W-1:0]    word_q;
    logic [CLK_DIV_W-1:0] div_q, cnt;
    logic [2:0]           bit_idx;
    logic [BI_W-1:0]      byte_idx;
    logic [7:0]           cur_byte;
    logic                 tick, framing, par_bit, tx_d;

    assign framing = (state == S_START) | (state == S_DATA) |
                     (state == S_PARITY) | (state == S_STOP);
    assign tick    = framing & (cnt == div_q - DIV_ONE);

    always_comb begin
        cur_byte = '0;
        for (int k = 0; k < BYTE_WIDTH; k++) begin
            if (byte_idx == BI_W'(k)) begin
                if (BIG_ENDIAN != 0) cur_byte = word_q[8*(BYTE_WIDTH-1-k) +: 8];
                else                 cur_byte = word_q[8*k +: 8];
            end
        end
    end

    assign par_bit = (PARITY == 1) ? ~(^(cur_byte & DATA_MASK)) : ^(cur_byte & DATA_MASK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            div_q    <= DIV_MIN;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
        end else begin
            // Divisor is only sampled here, so a frame in flight never changes rate.
            if (state == S_LOAD) begin
                word_q <= rd_data;
                div_q  <= (cfg_div < DIV_MIN) ? DIV_MIN : cfg_div;
            end
            if (state == S_LOAD || tick) cnt <= '0;
            else if (framing)            cnt <= cnt + DIV_ONE;
            if (state_nx != state) bit_idx <= '0;
            else if (tick)         bit_idx <= bit_idx + 3'd1;
            if (state == S_LOAD)                               byte_idx <= '0;
            else if (state == S_STOP && state_nx == S_START)   byte_idx <= byte_idx + BYTE_ONE;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (pop) state_nx = S_LOAD;
            S_LOAD:   state_nx = S_START;
            S_START:  if (tick) state_nx = S_DATA;
            S_DATA:   if (tick && bit_idx == LAST_DBIT)
                          state_nx = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick) state_nx = S_STOP;
            S_STOP:   if (tick && bit_idx == LAST_SBIT)
                          state_nx = (byte_idx == LAST_BYTE) ? S_IDLE : S_START;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        case (state)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte[bit_idx];
            S_PARITY: tx_d = par_bit;
            default:  tx_d = 1'b1;
        endcase
    end

    // Line is registered: it trails the state by one cycle, giving the
    // write-to-start-bit latency of three edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_uart_tx <= 1'b1;
        else     o_uart_tx <= tx_d;
    end

    assign idle = (state == S_IDLE) & empty;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: 2-byte words, big-endian, 7 data bits, odd parity,
// 2 stop bits, CTS enabled, 7-word FIFO. Frames are decoded off the line.
module tb_uart_tx_cfg;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_div;
    logic        wreq;
    logic        wgnt;
    logic [15:0] wdata;
    logic [2:0]  fifo_level;
    logic        i_cts_n;
    logic        idle;
    logic        o_uart_tx;

    uart_tx_cfg #(
        .CLK_DIV_W(16), .FIFO_ASIZE(3), .BYTE_WIDTH(2), .BIG_ENDIAN(1),
        .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .USE_CTS(1)
    ) dut (
        .clk(clk), .rst(rst), .cfg_div(cfg_div), .wreq(wreq), .wgnt(wgnt),
        .wdata(wdata), .fifo_level(fifo_level), .i_cts_n(i_cts_n),
        .idle(idle), .o_uart_tx(o_uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] data;
        logic       par;
        int         div;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Big-endian word: high byte goes out first; bit 7 is dropped, odd parity.
    task automatic push_word(input logic [15:0] w, input int d);
        logic [7:0] b;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            b      = (k == 0) ? w[15:8] : w[7:0];
            e.data = b[6:0];
            e.par  = ~(^b[6:0]);
            e.div  = d;
            sb.push_back(e);
        end
    endtask

    task automatic write_word(input logic [15:0] w, input int d);
        logic g;
        g = 1'b0;
        @(negedge clk);
        wreq  = 1'b1;
        wdata = w;
        repeat (200) begin
            #1 g = wgnt;
            @(posedge clk);
            if (g) break;
            @(negedge clk);
        end
        if (g) push_word(w, d);
        #1 wreq = 1'b0;
        chk("write_accept", 32'(g), 32'd1);
    endtask

    task automatic wait_line_low();
        logic seen;
        seen = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (!o_uart_tx) begin seen = 1'b1; break; end
        end
        chk("line_fell", 32'(seen), 32'd1);
    endtask

    task automatic wait_sb(input int remain, input int limit);
        repeat (limit) begin
            if (sb.size() <= remain) break;
            @(negedge clk);
        end
        chk("sb_level", 32'(sb.size()), 32'(remain));
        repeat (4) @(negedge clk);
    endtask

    // Write into an empty, idle transmitter: line must drop on the third edge.
    task automatic e3_test(input logic [15:0] w);
        @(negedge clk);
        wreq  = 1'b1;
        wdata = w;
        #1 chk("wgnt_on", 32'(wgnt), 32'd1);
        @(posedge clk);
        push_word(w, 32'(cfg_div));
        #1 wreq = 1'b0;
        chk("busy_idle", 32'(idle), 32'd0);
        chk("level_one", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        chk("tx_e1", 32'(o_uart_tx), 32'd1);
        chk("level_pop", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        chk("tx_e2", 32'(o_uart_tx), 32'd1);
        @(posedge clk); #1;
        chk("tx_e3", 32'(o_uart_tx), 32'd0);
        wait_sb(0, 2000);
        chk("idle_after", 32'(idle), 32'd1);
    endtask

    // Line monitor: samples every negedge across the whole frame so that bit
    // width, stop length and data are all checked exactly.
    initial begin : monitor
        logic        prev;
        logic [10:0] val;
        int          glitch, d;
        logic        abort;
        exp_t        e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b1;
            else if (prev && !o_uart_tx) begin
                chk("frame_expected", 32'(sb.size() != 0), 32'd1);
                d      = (sb.size() != 0) ? sb[0].div : 4;
                val    = '0;
                val[0] = o_uart_tx;
                glitch = 0;
                abort  = 1'b0;
                for (int j = 1; j < 11 * d; j++) begin
                    @(negedge clk);
                    if (rst) begin abort = 1'b1; break; end
                    if (j % d == 0) val[j/d] = o_uart_tx;
                    else if (o_uart_tx != val[j/d]) glitch++;
                end
                if (!abort && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("data", 32'(val[7:1]), 32'(e.data));
                    chk("parity", 32'(val[8]), 32'(e.par));
                    chk("stop", 32'(val[10:9]), 32'd3);
                    chk("bit_width", 32'(glitch), 32'd0);
                end
                prev = abort ? 1'b1 : o_uart_tx;
            end else prev = o_uart_tx;
        end
    end

    initial begin
        int         pulses;
        logic       line_hi;
        logic       g;
        logic [15:0] w;
        rst     = 1'b1;
        wreq    = 1'b0;
        wdata   = '0;
        cfg_div = 16'd4;
        i_cts_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(o_uart_tx), 32'd1);
        chk("rst_wgnt", 32'(wgnt), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // first frame latency and basic data
        e3_test(16'h1255);

        // bit 7 dropped: both bytes give the same 7-bit frame
        write_word(16'h41C1, 4);
        wait_sb(0, 2000);

        // divisors below two run at two cycles per bit
        cfg_div = 16'd1;
        write_word(16'h00FF, 2);
        wait_sb(0, 2000);
        cfg_div = 16'd0;
        write_word(16'h7F80, 2);
        wait_sb(0, 2000);
        cfg_div = 16'd4;

        // fill FIFO while CTS holds the transmitter off
        i_cts_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_empty_cts", 32'(idle), 32'd1);
        pulses  = 0;
        line_hi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            w     = 16'hA0C1 + 16'(i * 16'h0111);
            wreq  = 1'b1;
            wdata = w;
            #1 g  = wgnt;
            line_hi = line_hi & o_uart_tx;
            @(posedge clk);
            if (g) begin pulses++; push_word(w, 4); end
        end
        @(negedge clk);
        #1 chk("wgnt_full", 32'(wgnt), 32'd0);
        wreq = 1'b0;
        chk("wgnt_pulses", 32'(pulses), 32'd7);
        chk("level_full", 32'(fifo_level), 32'd7);
        chk("idle_cts_hold", 32'(idle), 32'd0);
        chk("line_cts_hold", 32'(line_hi), 32'd1);
        i_cts_n = 1'b0;
        wait_sb(0, 3000);
        chk("level_drained", 32'(fifo_level), 32'd0);

        // CTS dropped and divisor changed mid-word
        write_word(16'h3C5A, 4);
        wait_line_low();
        cfg_div = 16'd6;
        i_cts_n = 1'b1;
        write_word(16'h9669, 6);
        wait_sb(2, 2000);
        line_hi = 1'b1;
        repeat (60) begin
            @(negedge clk);
            line_hi = line_hi & o_uart_tx;
        end
        chk("cts_hold_line", 32'(line_hi), 32'd1);
        chk("cts_hold_idle", 32'(idle), 32'd0);
        chk("cts_hold_level", 32'(fifo_level), 32'd1);
        i_cts_n = 1'b0;
        wait_sb(0, 3000);
        cfg_div = 16'd4;

        // reset in the middle of data bits
        write_word(16'h5AA5, 4);
        wait_line_low();
        write_word(16'h1111, 4);
        chk("level_pre_rst", 32'(fifo_level), 32'd1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_tx", 32'(o_uart_tx), 32'd1);
        chk("rst_mid_level", 32'(fifo_level), 32'd0);
        chk("rst_mid_idle", 32'(idle), 32'd1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        e3_test(16'hC3A6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
